// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the matrix-keypad scanner.
//   scan_state_t            : scanner FSM states
//   width_of()              : $clog2 with a floor of one bit, for counter/index widths
//   DEFAULT_SETTLE_CYCLES   : column settle time at 10 MHz
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms stability window at 10 MHz
//   DEFAULT_FIFO_DEPTH      : key-code buffer entries
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE_P,
        HELD,
        DEBOUNCE_R
    } scan_state_t;

    localparam int DEFAULT_SETTLE_CYCLES   = 16;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;
    localparam int DEFAULT_FIFO_DEPTH      = 8;

    // A value range of 1 or 2 still needs a one-bit register.
    function automatic int width_of(input int max_value);
        return (max_value <= 2) ? 1 : $clog2(max_value);
    endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// keypad_code_fifo
// Show-ahead synchronous FIFO for key codes. The head entry is visible on
// head_data whenever the FIFO is non-empty; when empty, head_data keeps the
// last entry that was popped (zero after reset).
//   clk       : clock
//   reset     : synchronous, active-low; discards all contents
//   push      : write push_data (accepted when not full, or when full and popping)
//   push_data : entry to write
//   pop       : remove head entry (ignored when empty)
//   head_data : current head entry
//   full      : DEPTH entries stored
//   empty     : no entries stored
//   count     : number of entries stored
module keypad_code_fifo
    import keypad_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = width_of(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [WIDTH-1:0] last_data;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? last_data : mem[rd_ptr];

    // Pointers and occupancy. DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo
// Matrix-keypad scanner: drives one column at a time, samples the rows through
// a two-flop synchroniser, debounces press and release, and queues one
// {column, row} code per accepted press in a show-ahead FIFO.
//   clk       : system clock (10 MHz)
//   reset     : synchronous, active-low
//   row_in    : raw row lines, 1 = key closed in the driven column
//   col_drive : one-hot column drive
//   key_code  : FIFO head, {column index, row index}
//   key_valid : FIFO non-empty
//   key_ready : consumer takes key_code this cycle
//   key_held  : a press has been accepted and not yet released
//   overflow  : sticky, a code was dropped on a full FIFO
//   clr_ovf   : clears overflow (a simultaneous set wins)
module keypad_scan_fifo
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = DEFAULT_SETTLE_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [ROWS-1:0]                          row_in,
    output logic [COLS-1:0]                          col_drive,
    output logic [width_of(COLS)+width_of(ROWS)-1:0] key_code,
    output logic                                     key_valid,
    input  logic                                     key_ready,
    output logic                                     key_held,
    output logic                                     overflow,
    input  logic                                     clr_ovf
);

    localparam int CW = width_of(COLS);
    localparam int RW = width_of(ROWS);
    localparam int SW = width_of(SETTLE_CYCLES);
    localparam int DW = width_of(DEBOUNCE_CYCLES);

    localparam logic [SW-1:0] SETTLE_LAST   = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] COL_LAST      = CW'(COLS - 1);

    scan_state_t       state;
    scan_state_t       next_state;
    logic [ROWS-1:0]   row_meta;
    logic [ROWS-1:0]   row_s;
    logic [ROWS-1:0]   row_latch;
    logic [ROWS-1:0]   latch_next;
    logic [CW-1:0]     col_idx;
    logic [CW-1:0]     col_next;
    logic [SW-1:0]     settle_cnt;
    logic [SW-1:0]     settle_next;
    logic [DW-1:0]     deb_cnt;
    logic [DW-1:0]     deb_next;
    logic              push_req;
    logic [CW+RW-1:0]  push_code;
    logic              pop_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0] unused_fifo_count;

    function automatic logic [CW-1:0] advance_col(input logic [CW-1:0] col);
        return (col == COL_LAST) ? '0 : col + 1'b1;
    endfunction

    // Lowest closed row wins when several rows are closed at once.
    function automatic logic [RW-1:0] lowest_row(input logic [ROWS-1:0] rows);
        logic [RW-1:0] idx;
        idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (rows[i]) begin
                idx = RW'(i);
            end
        end
        return idx;
    endfunction

    assign col_drive = COLS'(1) << col_idx;
    assign key_held  = (state == HELD) || (state == DEBOUNCE_R);
    assign key_valid = !fifo_empty;
    assign pop_req   = key_valid && key_ready;
    assign push_code = {col_idx, lowest_row(row_latch)};

    // Scanner next-state logic: settle, sample, debounce press, hold, debounce release.
    always_comb begin
        next_state  = state;
        col_next    = col_idx;
        settle_next = settle_cnt;
        deb_next    = deb_cnt;
        latch_next  = row_latch;
        push_req    = 1'b0;
        case (state)
            SCAN: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_next = '0;
                    if (row_s == '0) begin
                        col_next = advance_col(col_idx);
                    end else begin
                        latch_next = row_s;
                        deb_next   = '0;
                        next_state = DEBOUNCE_P;
                    end
                end else begin
                    settle_next = settle_cnt + 1'b1;
                end
            end
            DEBOUNCE_P: begin
                if (row_s == '0) begin
                    next_state  = SCAN;
                    col_next    = advance_col(col_idx);
                    settle_next = '0;
                end else if (row_s != row_latch) begin
                    latch_next = row_s;
                    deb_next   = '0;
                end else if (deb_cnt == DEBOUNCE_LAST) begin
                    push_req   = 1'b1;
                    deb_next   = '0;
                    next_state = HELD;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (row_s == '0) begin
                    deb_next   = '0;
                    next_state = DEBOUNCE_R;
                end
            end
            DEBOUNCE_R: begin
                if (row_s != '0) begin
                    deb_next   = '0;
                    next_state = HELD;
                end else if (deb_cnt == DEBOUNCE_LAST) begin
                    deb_next    = '0;
                    settle_next = '0;
                    col_next    = advance_col(col_idx);
                    next_state  = SCAN;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            default: begin
                next_state = SCAN;
            end
        endcase
    end

    // State registers, synchroniser and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_meta   <= '0;
            row_s      <= '0;
            state      <= SCAN;
            col_idx    <= '0;
            settle_cnt <= '0;
            deb_cnt    <= '0;
            row_latch  <= '0;
            overflow   <= 1'b0;
        end else begin
            row_meta   <= row_in;
            row_s      <= row_meta;
            state      <= next_state;
            col_idx    <= col_next;
            settle_cnt <= settle_next;
            deb_cnt    <= deb_next;
            row_latch  <= latch_next;
            if (push_req && fifo_full && !pop_req) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    keypad_code_fifo #(
        .WIDTH (CW + RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_code),
        .pop       (pop_req),
        .head_data (key_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_fifo_count)
    );

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo
// Directed bench for keypad_scan_fifo with SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8,
// FIFO_DEPTH=4 and a 4x4 keypad. A behavioural keypad model drives row_in from
// the key state and the DUT's column drive. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_keypad_scan_fifo;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int SETTLE = 4;
    localparam int DEB    = 8;
    localparam int DEPTH  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [ROWS-1:0] row_in;
    logic [COLS-1:0] col_drive;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_ready;
    logic            key_held;
    logic            overflow;
    logic            clr_ovf;

    logic            key_down;
    logic [1:0]      key_col;
    logic [3:0]      key_rows;

    int n_checks = 0;
    int n_errors = 0;

    always #50 clk = ~clk;

    // Keypad model: a closed key only reaches its rows while its column is driven.
    always_comb begin
        row_in = '0;
        if (key_down && col_drive[key_col]) begin
            row_in = key_rows;
        end
    end

    keypad_scan_fifo #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_drive (col_drive),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_col(input logic [3:0] target, input string tag);
        int n = 0;
        while (col_drive !== target && n < 64) begin
            tick();
            n++;
        end
        check_output(tag, col_drive, target);
    endtask

    task automatic wait_held(input logic value, input string tag);
        int n = 0;
        while (key_held !== value && n < 64) begin
            tick();
            n++;
        end
        check_output(tag, key_held, value);
    endtask

    // Returns at the first falling edge after the target column becomes active,
    // with the key already closed so its rows appear as soon as the column is driven.
    task automatic arrive(input logic [1:0] col, input logic [3:0] rows);
        logic [3:0] target;
        int n = 0;
        target   = 4'b0001 << col;
        key_down = 1'b0;
        key_col  = col;
        key_rows = rows;
        while (col_drive === target && n < 64) begin
            tick();
            n++;
        end
        key_down = 1'b1;
        wait_col(target, "arrive_col");
    endtask

    // Clean press: close, wait for acceptance, hold briefly, release, wait for release.
    task automatic apply_stimulus(input logic [1:0] col, input logic [3:0] rows);
        arrive(col, rows);
        wait_held(1'b1, "press_held");
        tick(3);
        key_down = 1'b0;
        wait_held(1'b0, "press_released");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beats;
        int bad;
        logic [3:0] exp_codes [4];

        reset     = 1'b0;
        key_ready = 1'b0;
        clr_ovf   = 1'b0;
        key_down  = 1'b0;
        key_col   = 2'd0;
        key_rows  = 4'b0000;
        tick(3);

        $display("[TB] reset values");
        check_output("rst_col_drive", col_drive, 4'b0001);
        check_output("rst_key_valid", key_valid, 1'b0);
        check_output("rst_key_code", key_code, 4'h0);
        check_output("rst_key_held", key_held, 1'b0);
        check_output("rst_overflow", overflow, 1'b0);
        reset = 1'b1;
        tick();

        $display("[TB] clean press col 2 row 1");
        key_ready = 1'b1;
        arrive(2'd2, 4'b0010);
        tick(11);
        check_output("t1_valid_before_push", key_valid, 1'b0);
        check_output("t1_held_before_push", key_held, 1'b0);
        tick();
        check_output("t1_valid_beat", key_valid, 1'b1);
        check_output("t1_code", key_code, 4'b1001);
        check_output("t1_held_after_push", key_held, 1'b1);
        beats = 0;
        for (int i = 13; i <= 50; i++) begin
            tick();
            if (key_valid) beats++;
            if (i == 40) key_down = 1'b0;
        end
        check_output("t1_held_last_cycle", key_held, 1'b1);
        tick();
        check_output("t1_held_cleared", key_held, 1'b0);
        check_output("t1_next_col", col_drive, 4'b1000);
        check_output("t1_extra_beats", beats, 0);

        $display("[TB] bouncing press col 0 row 3");
        arrive(2'd0, 4'b1000);
        bad = 0;
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (key_valid || key_held) bad++;
            if (i == 3) key_down = 1'b0;
            if (i == 5) begin
                check_output("t2_col_held", col_drive, 4'b0001);
                key_down = 1'b1;
            end
            if (i == 8) key_down = 1'b0;
            if (i == 6)  check_output("t2_rot_col1", col_drive, 4'b0010);
            if (i == 10) check_output("t2_rot_col2", col_drive, 4'b0100);
            if (i == 14) check_output("t2_rot_col3", col_drive, 4'b1000);
            if (i == 18) check_output("t2_rot_col0", col_drive, 4'b0001);
            if (i == 22) check_output("t2_rot_col1_again", col_drive, 4'b0010);
        end
        check_output("t2_no_emit", bad, 0);

        $display("[TB] rows 1 and 3 at col 3 with release bounce");
        arrive(2'd3, 4'b1010);
        beats = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (key_valid) beats++;
            if (i == 12) check_output("t3_code", key_code, 4'b1101);
            if (i == 20) key_down = 1'b0;
            if (i == 25) key_down = 1'b1;
            if (i == 27) key_down = 1'b0;
            if (i == 28) check_output("t3_held_through_bounce", key_held, 1'b1);
            if (i == 37) check_output("t3_held_last_cycle", key_held, 1'b1);
            if (i == 38) check_output("t3_held_cleared", key_held, 1'b0);
        end
        check_output("t3_single_code", beats, 1);

        $display("[TB] fill FIFO with consumer stalled");
        key_ready = 1'b0;
        apply_stimulus(2'd0, 4'b0001);
        apply_stimulus(2'd1, 4'b0010);
        apply_stimulus(2'd2, 4'b0100);
        apply_stimulus(2'd3, 4'b1000);
        check_output("t4_valid_full", key_valid, 1'b1);
        check_output("t4_head_full", key_code, 4'h0);
        check_output("t4_no_ovf_at_full", overflow, 1'b0);
        apply_stimulus(2'd0, 4'b1000);
        check_output("t4_overflow_set", overflow, 1'b1);
        check_output("t4_head_unchanged", key_code, 4'h0);
        exp_codes[0] = 4'h0;
        exp_codes[1] = 4'h5;
        exp_codes[2] = 4'hA;
        exp_codes[3] = 4'hF;
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_output("t4_pop_valid", key_valid, 1'b1);
            check_output("t4_pop_code", key_code, exp_codes[i]);
            tick();
        end
        check_output("t4_empty", key_valid, 1'b0);
        check_output("t4_code_holds", key_code, 4'hF);
        key_ready = 1'b0;
        tick();
        check_output("t4_overflow_sticky", overflow, 1'b1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_output("t4_overflow_cleared", overflow, 1'b0);

        $display("[TB] full FIFO with pop on the push cycle");
        apply_stimulus(2'd0, 4'b0010);
        apply_stimulus(2'd1, 4'b0100);
        apply_stimulus(2'd2, 4'b1000);
        apply_stimulus(2'd3, 4'b0001);
        arrive(2'd0, 4'b0100);
        tick(11);
        check_output("t5_head_before", key_code, 4'h1);
        check_output("t5_held_before", key_held, 1'b0);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check_output("t5_valid_after", key_valid, 1'b1);
        check_output("t5_head_after", key_code, 4'h6);
        check_output("t5_no_overflow", overflow, 1'b0);
        check_output("t5_held_after", key_held, 1'b1);
        key_down = 1'b0;
        wait_held(1'b0, "t5_released");
        exp_codes[0] = 4'h6;
        exp_codes[1] = 4'hB;
        exp_codes[2] = 4'hC;
        exp_codes[3] = 4'h2;
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_output("t5_pop_code", key_code, exp_codes[i]);
            tick();
        end
        check_output("t5_empty", key_valid, 1'b0);
        key_ready = 1'b0;

        $display("[TB] reset during press debounce");
        apply_stimulus(2'd2, 4'b0001);
        arrive(2'd1, 4'b0001);
        tick(9);
        check_output("t6_valid_before_rst", key_valid, 1'b1);
        check_output("t6_code_before_rst", key_code, 4'h8);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        key_down = 1'b0;
        check_output("t6_valid", key_valid, 1'b0);
        check_output("t6_code", key_code, 4'h0);
        check_output("t6_col", col_drive, 4'b0001);
        check_output("t6_held", key_held, 1'b0);
        check_output("t6_overflow", overflow, 1'b0);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (key_valid || key_held) bad++;
        end
        check_output("t6_no_emit", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
Parametrised matrix-keypad scanner for ROWS x COLS keypads.
- Drives one column at a time and samples the raw row lines through a synchroniser.
- Debounces press and release internally, then emits one key code per press into a small FIFO.
- Downstream logic (7-segment driver, command parser) pops codes with a valid/ready handshake; overflow is flagged.

Parameters:
ROWS, 4, number of row inputs (>=2)
COLS, 4, number of driven columns (>=2)
SETTLE_CYCLES, 16, cycles a column is driven before its rows are sampled
DEBOUNCE_CYCLES, 100000, consecutive stable cycles needed to accept a press or release (10 ms at 10 MHz)
FIFO_DEPTH, 8, key-code buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock (10 MHz domain)
reset  in  1  synchronous, active-low reset
row_in  in  ROWS  raw row lines, asynchronous, 1 = key closed in driven column
col_drive  out  COLS  one-hot column drive, 1 = column active
key_code  out  CW+RW  FIFO head, {column index, row index}; CW=$clog2(COLS), RW=$clog2(ROWS)
key_valid  out  1  FIFO non-empty
key_ready  in  1  consumer accepts key_code this cycle
key_held  out  1  a press is accepted and not yet released
overflow  out  1  sticky: a code was dropped because the FIFO was full
clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- One clock and one reset: clk; reset synchronous, active-low. All state updates on posedge clk; reset (reset==0) takes priority over everything.
- Reset values:
  - col_drive = one-hot column 0; key_valid = 0; key_code = 0; key_held = 0; overflow = 0.
  - FIFO empty; FSM in SCAN; all counters 0.
- Synchroniser: row_in passes through 2 flops (row_s). All decisions use row_s only.
- FSM states: SCAN, DEBOUNCE_P, HELD, DEBOUNCE_R.
- SCAN:
  - Settle counter runs 0..SETTLE_CYCLES-1 on the current column.
  - At terminal count, sample row_s.
    - Zero: advance to the next column, wrapping COLS-1 -> 0, and restart the settle counter.
    - Non-zero: latch the row vector and go to DEBOUNCE_P; the column is held.
- DEBOUNCE_P:
  - Stability counter increments while row_s equals the latched vector.
  - Any change to a different non-zero vector: re-latch and clear the counter.
  - row_s == 0: return to SCAN, advancing to the next column; no code is emitted.
  - Counter reaching DEBOUNCE_CYCLES-1 with a match: push the code and go to HELD; key_held = 1 from the next cycle.
- Code format:
  - key_code = {col_idx, row_idx}.
  - row_idx = lowest set bit of the latched vector. Multiple simultaneous rows: the lowest index wins, others ignored (no rollover).
- HELD:
  - Column held, no further pushes however long the key is held.
  - row_s == 0 -> DEBOUNCE_R.
- DEBOUNCE_R:
  - Requires row_s == 0 for DEBOUNCE_CYCLES consecutive cycles, then go to SCAN on the next column with key_held = 0.
  - Any non-zero sample returns to HELD with the counter cleared; a bounce during release never emits a second code.
- FIFO:
  - Show-ahead. Push in cycle N -> key_valid = 1 and key_code valid in cycle N+1.
  - Pop occurs when key_valid && key_ready; key_code is stable while key_valid && !key_ready.
  - Full + push + pop in the same cycle: both occur, count unchanged, no overflow.
  - Full + push without pop: code dropped, overflow <= 1.
  - Empty: key_ready is ignored and key_code holds its last value.
- overflow: set as above, cleared by clr_ovf == 1. Set and clear in the same cycle -> set wins.
- Reset mid-operation (any state, any counter value):
  - Next cycle all reset values are restored; the FIFO contents are discarded.
  - A debounce in progress never emits.
- Counter widths: $clog2 of the respective maximum, minimum 1 bit; no wrap occurs inside a state.

Decomposition:
- keypad_pkg holds:
  - scan_state_t enum (SCAN, DEBOUNCE_P, HELD, DEBOUNCE_R)
  - a width helper function (clog2, minimum 1)
  - default constants for SETTLE_CYCLES and DEBOUNCE_CYCLES at 10 MHz
- Sub-module keypad_code_fifo: parametrised show-ahead synchronous FIFO (WIDTH, DEPTH) with push, pop, full, empty and count outputs. The top level contains the synchroniser, FSM, counters, priority encoder and overflow flag.

Test Plan:
- Bench overrides: SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8, FIFO_DEPTH=4, ROWS=COLS=4.
- Clean press at column 2, row 1 held 40 cycles, key_ready=1 -> exactly one key_valid beat with key_code=4'b1001; key_held high from the push cycle+1 until 8 stable-low cycles after release.
- Press at column 0, row 3 bouncing (high 3, low 2, high 3 cycles) then released -> no push; col_drive resumes one-hot rotation 0001->0010->0100->1000->0001.
- Rows 1 and 3 closed together at column 3 -> key_code=4'b1101; release bounce of 2 cycles during DEBOUNCE_R -> still a single code.
- key_ready=0, five distinct presses (codes 0x0, 0x5, 0xA, 0xF, 0x3) -> FIFO holds 0x0, 0x5, 0xA, 0xF, overflow=1. Then key_ready=1 pops them in order; clr_ovf pulse -> overflow=0.
- FIFO full with key_ready=1 on the push cycle of a new press -> pop and push both occur, overflow stays 0, order preserved.
- reset=0 for 1 cycle during DEBOUNCE_P at counter=5 -> key_valid=0, col_drive=4'b0001, FIFO empty, no code emitted afterwards for that press.
